// File: rtl/alarm_pkg.sv
// Shared types for the multi-channel alarm controller: channel states, BCD field
// widths, the packed alarm time and the write-time validity check.
package alarm_pkg;

    localparam int unsigned HH_W   = 2;
    localparam int unsigned HL_W   = 4;
    localparam int unsigned MH_W   = 3;
    localparam int unsigned ML_W   = 4;
    localparam int unsigned HOUR_W = HH_W + HL_W;
    localparam int unsigned MIN_W  = MH_W + ML_W;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        StDisarmed,
        StArmed,
        StRinging,
        StSnooze
    } alarm_state_e;

    typedef struct packed {
        logic [HH_W-1:0] hh;
        logic [HL_W-1:0] hl;
        logic [MH_W-1:0] mh;
        logic [ML_W-1:0] ml;
    } alarm_time_t;

    // Digits must be decimal and the hour must not exceed 23.
    function automatic logic bcd_time_valid(input alarm_time_t t);
        return (t.hh <= 2'd2) && (t.hl <= 4'd9) && (t.mh <= 3'd5) && (t.ml <= 4'd9) &&
               !((t.hh == 2'd2) && (t.hl > 4'd3));
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored BCD time, armed/ringing/snooze sequencing and a
// minute counter for ring auto-stop and snooze re-ring.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_MIN   = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         tick_d,
    input  alarm_time_t  now,
    input  logic         wr_en,
    input  alarm_time_t  wr_time,
    input  logic         wr_arm,
    input  logic         stop,
    input  logic         snooze,
    output alarm_time_t  alarm_time,
    output alarm_state_e state
);

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_MIN - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_MIN - 1);

    alarm_state_e     state_q, state_d;
    alarm_time_t      time_q, time_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match, ring_exp, snooze_exp;

    assign match      = tick_d && (now == time_q);
    assign ring_exp   = tick_d && (cnt_q == RING_LAST);
    assign snooze_exp = tick_d && (cnt_q == SNOOZE_LAST);

    // Priority: write, stop, snooze, counter expiry, match.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        if (wr_en) begin
            time_d  = wr_time;
            state_d = wr_arm ? StArmed : StDisarmed;
        end else begin
            case (state_q)
                StArmed: begin
                    if (match) state_d = StRinging;
                end
                StRinging: begin
                    if (stop)          state_d = StArmed;
                    else if (snooze)   state_d = StSnooze;
                    else if (ring_exp) state_d = StArmed;
                end
                StSnooze: begin
                    if (stop)            state_d = StArmed;
                    else if (snooze_exp) state_d = StRinging;
                end
                default: ;
            endcase
        end
    end

    // A write counts as a state entry even if the state value is unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (tick_d && ((state_q == StRinging) || (state_q == StSnooze))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StDisarmed;
            time_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alarm_time = time_q;
    assign state      = state_q;

endmodule

// File: rtl/multi_alarm_ctrl.sv
// N-channel alarm controller: minute-tick delay, write validation, readback mux,
// ring/snooze status and the blinking alarm LED.
module multi_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned N_ALARM    = 2,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_MIN   = 1,
    localparam int unsigned SEL_W     = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MINTICK,
    input  logic               SIG2HZ,
    input  logic [HH_W-1:0]    HOURH,
    input  logic [HL_W-1:0]    HOURL,
    input  logic [MH_W-1:0]    MINH,
    input  logic [ML_W-1:0]    MINL,
    input  logic               WR_EN,
    input  logic [SEL_W-1:0]   WR_SEL,
    input  logic [HOUR_W-1:0]  WR_HOUR,
    input  logic [MIN_W-1:0]   WR_MIN,
    input  logic               WR_ARM,
    input  logic               STOP,
    input  logic               SNOOZE,
    output logic [HOUR_W-1:0]  RD_HOUR,
    output logic [MIN_W-1:0]   RD_MIN,
    output logic               RD_ARM,
    output logic [N_ALARM-1:0] ACTIVE,
    output logic               SNOOZING,
    output logic               RING,
    output logic               LED,
    output logic               WR_ERR
);

    logic         tick_d;
    logic         led_q, wr_err_q;
    logic         sel_ok, wr_ok;
    alarm_time_t  now, wr_time, rd_time;
    logic         rd_arm;
    logic [N_ALARM-1:0] snoozing_ch;
    alarm_time_t  ch_time  [N_ALARM];
    alarm_state_e ch_state [N_ALARM];

    assign now     = '{hh: HOURH, hl: HOURL, mh: MINH, ml: MINL};
    assign wr_time = '{hh: WR_HOUR[HOUR_W-1:HL_W], hl: WR_HOUR[HL_W-1:0],
                       mh: WR_MIN[MIN_W-1:ML_W], ml: WR_MIN[ML_W-1:0]};

    assign sel_ok = 32'(WR_SEL) < N_ALARM;
    assign wr_ok  = WR_EN && sel_ok && bcd_time_valid(wr_time);

    for (genvar i = 0; i < N_ALARM; i++) begin : g_ch
        alarm_channel #(
            .SNOOZE_MIN (SNOOZE_MIN),
            .RING_MIN   (RING_MIN)
        ) u_ch (
            .CLK        (CLK),
            .RST        (RST),
            .tick_d     (tick_d),
            .now        (now),
            .wr_en      (wr_ok && (32'(WR_SEL) == 32'(i))),
            .wr_time    (wr_time),
            .wr_arm     (WR_ARM),
            .stop       (STOP),
            .snooze     (SNOOZE),
            .alarm_time (ch_time[i]),
            .state      (ch_state[i])
        );

        assign ACTIVE[i]      = (ch_state[i] == StRinging);
        assign snoozing_ch[i] = (ch_state[i] == StSnooze);
    end

    // Out-of-range selects read back as zero rather than indexing past the array.
    always_comb begin
        rd_time = '0;
        rd_arm  = 1'b0;
        for (int unsigned i = 0; i < N_ALARM; i++) begin
            if (32'(WR_SEL) == i) begin
                rd_time = ch_time[i];
                rd_arm  = (ch_state[i] != StDisarmed);
            end
        end
    end

    assign RD_HOUR  = {rd_time.hh, rd_time.hl};
    assign RD_MIN   = {rd_time.mh, rd_time.ml};
    assign RD_ARM   = rd_arm;
    assign RING     = |ACTIVE;
    assign SNOOZING = |snoozing_ch;
    assign LED      = led_q;
    assign WR_ERR   = wr_err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tick_d   <= 1'b0;
            led_q    <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            tick_d   <= MINTICK;
            led_q    <= RING & SIG2HZ;
            wr_err_q <= WR_EN & ~wr_ok;
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Scoreboard bench for multi_alarm_ctrl with three channels so that an
// out-of-range write select is expressible.
module tb_multi_alarm_ctrl;
    import alarm_pkg::*;

    localparam int unsigned N = 3;

    logic       CLK = 1'b0, RST = 1'b0, MINTICK = 1'b0, SIG2HZ = 1'b0;
    logic [1:0] HOURH = '0;
    logic [3:0] HOURL = '0;
    logic [2:0] MINH = '0;
    logic [3:0] MINL = '0;
    logic       WR_EN = 1'b0, WR_ARM = 1'b0, STOP = 1'b0, SNOOZE = 1'b0;
    logic [1:0] WR_SEL = '0;
    logic [5:0] WR_HOUR = '0;
    logic [6:0] WR_MIN = '0;
    logic [5:0] RD_HOUR;
    logic [6:0] RD_MIN;
    logic       RD_ARM, SNOOZING, RING, LED, WR_ERR;
    logic [N-1:0] ACTIVE;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    multi_alarm_ctrl #(.N_ALARM(N), .SNOOZE_MIN(5), .RING_MIN(1)) dut (
        .CLK(CLK), .RST(RST), .MINTICK(MINTICK), .SIG2HZ(SIG2HZ),
        .HOURH(HOURH), .HOURL(HOURL), .MINH(MINH), .MINL(MINL),
        .WR_EN(WR_EN), .WR_SEL(WR_SEL), .WR_HOUR(WR_HOUR), .WR_MIN(WR_MIN), .WR_ARM(WR_ARM),
        .STOP(STOP), .SNOOZE(SNOOZE),
        .RD_HOUR(RD_HOUR), .RD_MIN(RD_MIN), .RD_ARM(RD_ARM),
        .ACTIVE(ACTIVE), .SNOOZING(SNOOZING), .RING(RING), .LED(LED), .WR_ERR(WR_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic set_time(input logic [5:0] h, input logic [6:0] m);
        {HOURH, HOURL} = h;
        {MINH, MINL}   = m;
    endtask

    // Returns at the negedge two cycles after MINTICK, when a match is visible.
    task automatic tick(input logic [5:0] h, input logic [6:0] m);
        @(negedge CLK);
        set_time(h, m);
        MINTICK = 1'b1;
        @(negedge CLK);
        MINTICK = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [5:0] h, input logic [6:0] m,
                      input logic arm);
        @(negedge CLK);
        WR_EN = 1'b1; WR_SEL = sel; WR_HOUR = h; WR_MIN = m; WR_ARM = arm;
        @(negedge CLK);
        WR_EN = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge CLK); STOP = 1'b1;
        @(negedge CLK); STOP = 1'b0;
    endtask

    task automatic pulse_snooze();
        @(negedge CLK); SNOOZE = 1'b1;
        @(negedge CLK); SNOOZE = 1'b0;
    endtask

    task automatic test_reset();
        sb.push_back('{name: "rst_status", exp: 32'h0});
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        e = sb.pop_front(); n_tests++;
        if ({ACTIVE, SNOOZING, RING, LED, WR_ERR} !== e.exp[N+3:0]) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", e.name,
                     {ACTIVE, SNOOZING, RING, LED, WR_ERR}, e.exp);
        end
        for (int i = 0; i < N; i++) begin
            WR_SEL = 2'(i);
            sb.push_back('{name: $sformatf("rst_readback_ch%0d", i), exp: 32'h0});
            #1;
            e = sb.pop_front(); n_tests++;
            if (32'({RD_ARM, RD_HOUR, RD_MIN}) !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h", e.name, {RD_ARM, RD_HOUR, RD_MIN}, e.exp);
            end
        end
    endtask

    task automatic test_match();
        set_time(6'h07, 7'h29);
        sb.push_back('{name: "match_wr_readback", exp: 32'({1'b1, 6'h07, 7'h30, 1'b0})});
        wr(2'd0, 6'h07, 7'h30, 1'b1);
        e = sb.pop_front(); n_tests++;
        if (32'({RD_ARM, RD_HOUR, RD_MIN, WR_ERR}) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", e.name,
                     {RD_ARM, RD_HOUR, RD_MIN, WR_ERR}, e.exp);
        end
        sb.push_back('{name: "match_t1_quiet", exp: 32'h0});
        sb.push_back('{name: "match_t2_active", exp: 32'h1});
        sb.push_back('{name: "match_ring", exp: 32'h1});
        @(negedge CLK);
        set_time(6'h07, 7'h30);
        MINTICK = 1'b1;
        @(negedge CLK);
        MINTICK = 1'b0;
        e = sb.pop_front(); n_tests++;
        if (32'(ACTIVE) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, ACTIVE, e.exp);
        end
        @(negedge CLK);
        e = sb.pop_front(); n_tests++;
        if (32'(ACTIVE) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, ACTIVE, e.exp);
        end
        e = sb.pop_front(); n_tests++;
        if (32'(RING) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, RING, e.exp);
        end
        sb.push_back('{name: "led_on", exp: 32'h1});
        sb.push_back('{name: "led_off", exp: 32'h0});
        SIG2HZ = 1'b1;
        @(negedge CLK);
        e = sb.pop_front(); n_tests++;
        if (32'(LED) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, LED, e.exp);
        end
        SIG2HZ = 1'b0;
        @(negedge CLK);
        e = sb.pop_front(); n_tests++;
        if (32'(LED) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, LED, e.exp);
        end
    endtask

    task automatic test_auto_stop();
        WR_SEL = 2'd0;
        sb.push_back('{name: "autostop_still_armed", exp: 32'({3'b000, 1'b1})});
        tick(6'h07, 7'h31);
        e = sb.pop_front(); n_tests++;
        if (32'({ACTIVE, RD_ARM}) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, {ACTIVE, RD_ARM}, e.exp);
        end
        sb.push_back('{name: "autostop_next_day", exp: 32'h1});
        tick(6'h07, 7'h30);
        e = sb.pop_front(); n_tests++;
        if (32'(ACTIVE) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, ACTIVE, e.exp);
        end
    endtask

    task automatic test_snooze();
        sb.push_back('{name: "snooze_enter", exp: 32'({3'b000, 1'b1, 1'b0})});
        pulse_snooze();
        e = sb.pop_front(); n_tests++;
        if (32'({ACTIVE, SNOOZING, RING}) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", e.name, {ACTIVE, SNOOZING, RING}, e.exp);
        end
        for (int k = 1; k <= 5; k++) begin
            if (k == 4) sb.push_back('{name: "snooze_tick4_quiet", exp: 32'({3'b000, 1'b1})});
            if (k == 5) sb.push_back('{name: "snooze_tick5_rering", exp: 32'({3'b001, 1'b0})});
            tick(6'h07, 7'(7'h30 + 7'(k)));
            if (k >= 4) begin
                e = sb.pop_front(); n_tests++;
                if (32'({ACTIVE, SNOOZING}) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0h, expected %0h", e.name, {ACTIVE, SNOOZING}, e.exp);
                end
            end
        end
        sb.push_back('{name: "snooze_stop", exp: 32'({3'b000, 1'b1})});
        WR_SEL = 2'd0;
        pulse_stop();
        e = sb.pop_front(); n_tests++;
        if (32'({ACTIVE, RD_ARM}) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, {ACTIVE, RD_ARM}, e.exp);
        end
        sb.push_back('{name: "snooze_ignored_when_armed", exp: 32'h0});
        pulse_snooze();
        e = sb.pop_front(); n_tests++;
        if (32'({ACTIVE, SNOOZING}) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", e.name, {ACTIVE, SNOOZING}, e.exp);
        end
    endtask

    task automatic test_write_errors();
        logic [1:0] bad_sel [3];
        logic [5:0] bad_h   [3];
        logic [6:0] bad_m   [3];
        bad_sel = '{2'd0, 2'd0, 2'd3};
        bad_h   = '{6'h24, 6'h12, 6'h12};
        bad_m   = '{7'h00, 7'h60, 7'h00};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{name: $sformatf("wr_err_pulse%0d", i), exp: 32'h1});
            sb.push_back('{name: $sformatf("wr_err_clear%0d", i), exp: 32'h0});
            wr(bad_sel[i], bad_h[i], bad_m[i], 1'b1);
            e = sb.pop_front(); n_tests++;
            if (32'(WR_ERR) !== e.exp) begin
                n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, WR_ERR, e.exp);
            end
            @(negedge CLK);
            e = sb.pop_front(); n_tests++;
            if (32'(WR_ERR) !== e.exp) begin
                n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, WR_ERR, e.exp);
            end
        end
        WR_SEL = 2'd0;
        sb.push_back('{name: "wr_err_unchanged", exp: 32'({1'b1, 6'h07, 7'h30})});
        #1;
        e = sb.pop_front(); n_tests++;
        if (32'({RD_ARM, RD_HOUR, RD_MIN}) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", e.name, {RD_ARM, RD_HOUR, RD_MIN}, e.exp);
        end
        sb.push_back('{name: "wr_2359_ok", exp: 32'({1'b0, 6'h23, 7'h59, 1'b0})});
        wr(2'd2, 6'h23, 7'h59, 1'b0);
        e = sb.pop_front(); n_tests++;
        if (32'({RD_ARM, RD_HOUR, RD_MIN, WR_ERR}) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", e.name,
                     {RD_ARM, RD_HOUR, RD_MIN, WR_ERR}, e.exp);
        end
    endtask

    task automatic test_two_channels();
        wr(2'd0, 6'h06, 7'h00, 1'b1);
        wr(2'd1, 6'h06, 7'h00, 1'b1);
        sb.push_back('{name: "dual_match", exp: 32'h3});
        sb.push_back('{name: "dual_stop", exp: 32'h0});
        sb.push_back('{name: "dual_match_again", exp: 32'h3});
        sb.push_back('{name: "dual_disarm_ch1", exp: 32'({3'b001, 1'b0})});
        tick(6'h06, 7'h00);
        e = sb.pop_front(); n_tests++;
        if (32'(ACTIVE) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, ACTIVE, e.exp);
        end
        pulse_stop();
        e = sb.pop_front(); n_tests++;
        if (32'(ACTIVE) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, ACTIVE, e.exp);
        end
        tick(6'h06, 7'h00);
        e = sb.pop_front(); n_tests++;
        if (32'(ACTIVE) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, ACTIVE, e.exp);
        end
        wr(2'd1, 6'h06, 7'h00, 1'b0);
        e = sb.pop_front(); n_tests++;
        if (32'({ACTIVE, RD_ARM}) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, {ACTIVE, RD_ARM}, e.exp);
        end
    endtask

    task automatic test_reset_mid_ring();
        sb.push_back('{name: "midring_led_before", exp: 32'h1});
        sb.push_back('{name: "midring_async_clear", exp: 32'h0});
        sb.push_back('{name: "midring_led_held", exp: 32'h0});
        SIG2HZ = 1'b1;
        @(negedge CLK);
        e = sb.pop_front(); n_tests++;
        if (32'(LED) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, LED, e.exp);
        end
        #1 RST = 1'b0;
        #1;
        e = sb.pop_front(); n_tests++;
        if (32'({ACTIVE, RING, LED}) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, {ACTIVE, RING, LED}, e.exp);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        e = sb.pop_front(); n_tests++;
        if (32'({ACTIVE, LED}) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, {ACTIVE, LED}, e.exp);
        end
        SIG2HZ = 1'b0;
        for (int i = 0; i < N; i++) begin
            WR_SEL = 2'(i);
            sb.push_back('{name: $sformatf("midring_readback_ch%0d", i), exp: 32'h0});
            #1;
            e = sb.pop_front(); n_tests++;
            if (32'({RD_ARM, RD_HOUR}) !== e.exp) begin
                n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, {RD_ARM, RD_HOUR}, e.exp);
            end
        end
    endtask

    task automatic test_wrap();
        set_time(6'h23, 7'h59);
        wr(2'd1, 6'h23, 7'h59, 1'b1);
        wr(2'd2, 6'h00, 7'h00, 1'b1);
        sb.push_back('{name: "wr_now_no_fire", exp: 32'h0});
        sb.push_back('{name: "wrap_midnight", exp: 32'h4});
        repeat (3) @(negedge CLK);
        e = sb.pop_front(); n_tests++;
        if (32'(ACTIVE) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, ACTIVE, e.exp);
        end
        tick(6'h00, 7'h00);
        e = sb.pop_front(); n_tests++;
        if (32'(ACTIVE) !== e.exp) begin
            n_fail++; $display("FAIL %s: got %0h, expected %0h", e.name, ACTIVE, e.exp);
        end
        pulse_stop();
    endtask

    initial begin
        test_reset();
        test_match();
        test_auto_stop();
        test_snooze();
        test_write_errors();
        test_two_channels();
        test_reset_mid_ring();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multi_alarm_ctrl.md
# multi_alarm_ctrl

- Parametrised N-channel alarm controller for the 24-hour clock.
- Holds N BCD alarm times and compares them against the running HH:MM at each minute rollover.
- Each channel is sequenced through armed, ringing and snooze states, with snooze and auto-timeout counted in minutes.
- Drives a blinking alarm LED and per-channel status; sits beside the hour/minute counters and feeds the display multiplexer.

## Interface
Parameters:
- N_ALARM, 2: number of alarm channels (1..8).
- SNOOZE_MIN, 5: minutes a snoozed channel waits before re-ringing (1..15).
- RING_MIN, 1: minutes a channel rings unanswered before auto-stop (1..15).

Ports:
- CLK  in  1  system clock, single clock domain.
- RST  in  1  asynchronous, active-low reset.
- MINTICK  in  1  one-cycle pulse, minute carry from the seconds counter.
- SIG2HZ  in  1  2 Hz square wave for blinking.
- HOURH, HOURL, MINH, MINL  in  2/4/3/4  current time in BCD.
- WR_EN  in  1  one-cycle write strobe.
- WR_SEL  in  $clog2(N_ALARM) (min 1)  channel to write or read back.
- WR_HOUR  in  6  {HH[1:0], HL[3:0]} BCD.
- WR_MIN  in  7  {MH[2:0], ML[3:0]} BCD.
- WR_ARM  in  1  arm bit written with the time.
- STOP, SNOOZE  in  1  debounced one-cycle button pulses.
- RD_HOUR, RD_MIN, RD_ARM  out  6/7/1  combinational readback of channel WR_SEL.
- ACTIVE  out  N_ALARM  channel is RINGING, registered.
- SNOOZING  out  1  any channel is in SNOOZE, registered.
- RING  out  1  OR of ACTIVE.
- LED  out  1  RING & SIG2HZ, registered.
- WR_ERR  out  1  one-cycle pulse when a write is rejected.

## Operation
Per-channel states:
- DISARMED: not armed; ignores time matches.
- ARMED → RINGING: on a match cycle where the stored time equals the current time.
- RINGING → ARMED: on STOP, or after RING_MIN minute ticks with no STOP (auto-stop). The channel remains armed for the next day.
- RINGING → SNOOZE: on SNOOZE.
- SNOOZE → RINGING: after SNOOZE_MIN minute ticks.
- SNOOZE → ARMED: on STOP.

Match cycle:
- MINTICK is registered into `tick_d`; comparison happens only when `tick_d` = 1, i.e. after the counters have updated.
- Writing an alarm equal to the current time therefore never fires until that time next recurs.

Counters:
- One 4-bit minute counter per channel, counting `tick_d`.
- Cleared on every state entry.
- Comparisons against the parameter are equality tests.

Buttons:
- STOP and SNOOZE act on every channel currently RINGING; STOP also acts on SNOOZE channels.
- SNOOZE has no effect on ARMED or DISARMED channels.

Writes:
- A write is accepted only if HH ≤ 2, HL ≤ 9, MH ≤ 5, ML ≤ 9 and HH:HL ≤ 23.
- An accepted write loads the time and sets the state to ARMED if WR_ARM = 1, else DISARMED. This cancels any ringing or snooze on that channel.
- An invalid write leaves the channel unchanged and pulses WR_ERR.
- WR_SEL ≥ N_ALARM counts as invalid.

Per-channel priority when events coincide (highest first): write, STOP, SNOOZE, counter expiry, match.

## Timing
Reset:
- RST low asynchronously sets every channel to DISARMED with time 00:00 and counters 0.
- It also clears ACTIVE, SNOOZING, RING, LED, WR_ERR and `tick_d`.
- Reset in the middle of ringing silences LED at once, with no further pulses.

Latency:
- MINTICK high in cycle t: `tick_d` = 1 in cycle t+1; ACTIVE/RING high in cycle t+2; LED follows RING one cycle later, gated by SIG2HZ.
- STOP or SNOOZE in cycle t: ACTIVE drops in cycle t+1.
- Write in cycle t: the state updates in t+1; WR_ERR is high in t+1 only.

Timeouts are counted in `tick_d` pulses:
- Auto-stop occurs on the RING_MIN-th tick after entering RINGING.
- Re-ring occurs on the SNOOZE_MIN-th tick after entering SNOOZE.

Other rules:
- Match wrap at 23:59 → 00:00 needs no special case, because the comparison is on the BCD values.
- A `tick_d` that both expires a counter and matches the time takes the expiry transition.

## Structure
- Package `alarm_pkg`:
  - state enum (DISARMED, ARMED, RINGING, SNOOZE)
  - BCD field widths
  - packed time struct {hh, hl, mh, ml}
  - function `bcd_time_valid`
- Sub-module `alarm_channel`: one per channel, instantiated via generate. It holds the time register, state, minute counter and compare.
- Top level holds `tick_d`, write decode and validation, readback mux, output OR-reduction, and the LED/WR_ERR registers.

## Test plan
- Reset, then write ch0 = 07:30 armed; drive time 07:29 and pulse MINTICK so the time becomes 07:30 → ACTIVE[0] = 1 exactly 2 cycles after MINTICK; LED toggles with SIG2HZ.
- Ringing ch0, no STOP, one more MINTICK with RING_MIN = 1 → ACTIVE[0] = 0; the channel is still ARMED and rings again at 07:30 the next simulated day.
- Ringing ch0, pulse SNOOZE → SNOOZING = 1, RING = 0; after 5 MINTICKs → ACTIVE[0] = 1; then STOP → ACTIVE = 0.
- Write 24:00, 12:60 and WR_SEL = N_ALARM → WR_ERR pulses once for each; readback is unchanged.
- ch0 = ch1 = 06:00 both armed, match → ACTIVE = 2'b11; a single STOP clears both; write ch1 with WR_ARM = 0 while ringing → ACTIVE[1] = 0 next cycle.
- Assert RST low mid-ring → RING, LED, ACTIVE = 0 immediately; after release, RD_HOUR = 0 and RD_ARM = 0 for all channels.
